// File: rtl/dcache_pkg.sv
// Shared dcache definitions: miss-controller state encodings and the
// offset-width derivations used by the controller and the tag/index split.
package dcache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WB_READ = 3'd1,
    ST_WB_SEND = 3'd2,
    ST_RF_REQ  = 3'd3,
    ST_RF_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } miss_state_e;

  // Width of the word index within a line.
  function automatic int calc_off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  // Width of the byte offset within a line.
  function automatic int calc_line_off_w(input int line_words, input int data_w);
    return $clog2(line_words * (data_w / 8));
  endfunction

endpackage

// File: rtl/dcache_miss_ctrl.sv
// Write-back dcache miss controller: optional dirty-victim write-back followed
// by a word-by-word line refill, one miss at a time.
module dcache_miss_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  localparam int OFF_W     = calc_off_w(LINE_WORDS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              miss_valid,
  output logic              miss_ready,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              miss_dirty,
  input  logic [ADDR_W-1:0] victim_addr,
  output logic              arr_rd_en,
  output logic [OFF_W-1:0]  arr_rd_idx,
  input  logic [DATA_W-1:0] arr_rd_data,
  output logic              arr_wr_en,
  output logic [OFF_W-1:0]  arr_wr_idx,
  output logic [DATA_W-1:0] arr_wr_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done
);

  localparam int                LINE_OFF_W = calc_line_off_w(LINE_WORDS, DATA_W);
  localparam logic [ADDR_W-1:0] BASE_MASK  = ~((ADDR_W'(1) << LINE_OFF_W) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);
  localparam logic [OFF_W-1:0]  LAST_IDX   = OFF_W'(LINE_WORDS - 1);

  miss_state_e       state_reg, state_next;
  logic [OFF_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] miss_base_reg, miss_base_next;
  logic [ADDR_W-1:0] victim_base_reg, victim_base_next;
  logic [ADDR_W-1:0] word_off;

  assign word_off = ADDR_W'(cnt_reg) * WORD_BYTES;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      miss_base_reg   <= '0;
      victim_base_reg <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      miss_base_reg   <= miss_base_next;
      victim_base_reg <= victim_base_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    miss_base_next   = miss_base_reg;
    victim_base_next = victim_base_reg;
    miss_ready       = 1'b0;
    arr_rd_en        = 1'b0;
    arr_rd_idx       = '0;
    arr_wr_en        = 1'b0;
    arr_wr_idx       = '0;
    arr_wr_data      = '0;
    mem_valid        = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    done             = 1'b0;
    busy             = (state_reg != ST_IDLE);

    case (state_reg)
      ST_IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          miss_base_next   = miss_addr & BASE_MASK;
          victim_base_next = victim_addr & BASE_MASK;
          cnt_next         = '0;
          state_next       = miss_dirty ? ST_WB_READ : ST_RF_REQ;
        end
      end

      ST_WB_READ: begin
        arr_rd_en  = 1'b1;
        arr_rd_idx = cnt_reg;
        state_next = ST_WB_SEND;
      end

      // arr_rd_data holds until the next read strobe, so the write payload
      // stays stable across any number of mem_ready stall cycles.
      ST_WB_SEND: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = victim_base_reg + word_off;
        mem_wdata = arr_rd_data;
        if (mem_ready) begin
          if (cnt_reg == LAST_IDX) begin
            cnt_next   = '0;
            state_next = ST_RF_REQ;
          end else begin
            cnt_next   = cnt_reg + OFF_W'(1);
            state_next = ST_WB_READ;
          end
        end
      end

      ST_RF_REQ: begin
        mem_valid = 1'b1;
        mem_addr  = miss_base_reg + word_off;
        if (mem_ready) begin
          state_next = ST_RF_WAIT;
        end
      end

      ST_RF_WAIT: begin
        if (mem_rvalid) begin
          arr_wr_en   = 1'b1;
          arr_wr_idx  = cnt_reg;
          arr_wr_data = mem_rdata;
          if (cnt_reg == LAST_IDX) begin
            state_next = ST_DONE;
          end else begin
            cnt_next   = cnt_reg + OFF_W'(1);
            state_next = ST_RF_REQ;
          end
        end
      end

      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl with a zero-wait memory model,
// optional stall injection and spurious-response injection.
module tb_dcache_miss_ctrl;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int OFF_W      = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              miss_valid = 1'b0;
  logic              miss_ready;
  logic [ADDR_W-1:0] miss_addr = '0;
  logic              miss_dirty = 1'b0;
  logic [ADDR_W-1:0] victim_addr = '0;
  logic              arr_rd_en;
  logic [OFF_W-1:0]  arr_rd_idx;
  logic [DATA_W-1:0] arr_rd_data = '0;
  logic              arr_wr_en;
  logic [OFF_W-1:0]  arr_wr_idx;
  logic [DATA_W-1:0] arr_wr_data;
  logic              mem_valid;
  logic              mem_ready = 1'b1;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              busy;
  logic              done;

  dcache_miss_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS)
  ) dut (
    .clock(clock), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .miss_dirty(miss_dirty), .victim_addr(victim_addr),
    .arr_rd_en(arr_rd_en), .arr_rd_idx(arr_rd_idx), .arr_rd_data(arr_rd_data),
    .arr_wr_en(arr_wr_en), .arr_wr_idx(arr_wr_idx), .arr_wr_data(arr_wr_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  int  cyc = 0, start_cyc = 0, done_rel = -1, done_abs = -1;
  bit  done_seen = 0;
  int  accept_cnt = 0;
  int  accept_cyc[$];
  logic        tx_we[$];
  logic [31:0] tx_addr[$];
  logic [31:0] tx_data[$];
  logic [1:0]  wr_idx[$];
  logic [31:0] wr_data[$];

  bit          read_pending = 0;
  logic [31:0] read_addr = '0;
  bit          rd_pending = 0;
  logic [1:0]  rd_pending_idx = '0;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int          stall_left = 0;
  bit          spur_on_stall = 0;
  bit          spur_rvalid = 0;
  bit          hold_valid = 0;
  bit          accepted_last = 0;
  bit          stall_ref_set = 0;
  logic [31:0] stall_ref_addr = '0, stall_ref_data = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] arr_word(input logic [1:0] idx);
    return 32'hD000_0000 + 32'(idx);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, sample/log shortly after.
  task automatic step();
    @(negedge clock);
    if (accepted_last && !hold_valid) miss_valid = 1'b0;
    accepted_last = 0;
    if (rd_pending) begin
      arr_rd_data = arr_word(rd_pending_idx);
      rd_pending  = 0;
    end
    mem_rvalid   = read_pending | spur_rvalid;
    mem_rdata    = read_pending ? mem_word(read_addr) : 32'hBAD0_BAD0;
    read_pending = 0;
    mem_ready    = 1'b1;
    #1;
    if (mem_valid && mem_addr == stall_addr && stall_left > 0) begin
      mem_ready = 1'b0;
      stall_left--;
      if (!stall_ref_set) begin
        stall_ref_addr = mem_addr;
        stall_ref_data = mem_wdata;
        stall_ref_set  = 1;
      end else begin
        chk("stall_addr_stable", mem_addr, stall_ref_addr);
        chk("stall_wdata_stable", mem_wdata, stall_ref_data);
      end
      if (spur_on_stall) begin
        mem_rvalid = 1'b1;
        #1;
        chk("spur_no_wr_en", 32'(arr_wr_en), 32'd0);
      end
    end
    #1;
    if (miss_valid && miss_ready) begin
      start_cyc = cyc;
      accept_cnt++;
      accept_cyc.push_back(cyc);
      accepted_last = 1;
      done_seen = 0;
    end
    if (mem_valid && mem_ready) begin
      tx_we.push_back(mem_we);
      tx_addr.push_back(mem_addr);
      tx_data.push_back(mem_wdata);
      if (!mem_we) begin
        read_pending = 1;
        read_addr    = mem_addr;
      end
    end
    if (arr_wr_en) begin
      wr_idx.push_back(arr_wr_idx);
      wr_data.push_back(arr_wr_data);
    end
    if (arr_rd_en) begin
      rd_pending     = 1;
      rd_pending_idx = arr_rd_idx;
    end
    if (done) begin
      done_seen = 1;
      done_rel  = cyc - start_cyc;
      done_abs  = cyc;
    end
    @(posedge clock);
    cyc++;
  endtask

  task automatic clear_logs();
    tx_we.delete(); tx_addr.delete(); tx_data.delete();
    wr_idx.delete(); wr_data.delete();
    accept_cyc.delete();
    accept_cnt = 0;
    done_rel = -1;
    stall_ref_set = 0;
  endtask

  task automatic start_miss(input logic [31:0] a, input logic dirty, input logic [31:0] v);
    #1;
    miss_addr   = a;
    miss_dirty  = dirty;
    victim_addr = v;
    miss_valid  = 1'b1;
  endtask

  task automatic run_to_done(input string tag, input int budget);
    int n = 0;
    done_seen = 0;
    while (!done_seen && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_seen), 32'd1);
  endtask

  task automatic check_refill(input string tag, input logic [31:0] base, input int first_tx);
    chk({tag, "_nwr"}, 32'(wr_idx.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_rd_we%0d", tag, i), 32'(tx_we[first_tx+i]), 32'd0);
      chk($sformatf("%s_rd_addr%0d", tag, i), tx_addr[first_tx+i], base + 32'(4*i));
      chk($sformatf("%s_wr_idx%0d", tag, i), 32'(wr_idx[i]), 32'(i));
      chk($sformatf("%s_wr_data%0d", tag, i), wr_data[i], mem_word(base + 32'(4*i)));
    end
  endtask

  task automatic check_writeback(input string tag, input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_wb_we%0d", tag, i), 32'(tx_we[i]), 32'd1);
      chk($sformatf("%s_wb_addr%0d", tag, i), tx_addr[i], base + 32'(4*i));
      chk($sformatf("%s_wb_data%0d", tag, i), tx_data[i], arr_word(2'(i)));
    end
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    #1;
    chk("rst_miss_ready", 32'(miss_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_arr_rd_en", 32'(arr_rd_en), 32'd0);
    chk("rst_arr_wr_en", 32'(arr_wr_en), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_arr_wr_data", arr_wr_data, 32'd0);
    reset = 1'b0;
    step();

    // Clean miss
    clear_logs();
    start_miss(32'h0000_1234, 1'b0, 32'h0);
    run_to_done("clean", 40);
    chk("clean_done_cyc", 32'(done_rel), 32'd9);
    chk("clean_ntx", 32'(tx_addr.size()), 32'd4);
    check_refill("clean", 32'h0000_1230, 0);

    // Dirty miss
    clear_logs();
    start_miss(32'h0000_4000, 1'b1, 32'h0000_8008);
    run_to_done("dirty", 60);
    chk("dirty_done_cyc", 32'(done_rel), 32'd17);
    chk("dirty_ntx", 32'(tx_addr.size()), 32'd8);
    check_writeback("dirty", 32'h0000_8000);
    check_refill("dirty", 32'h0000_4000, 4);

    // Backpressure on write word 2
    clear_logs();
    stall_addr = 32'h0000_8008;
    stall_left = 3;
    start_miss(32'h0000_4000, 1'b1, 32'h0000_8008);
    run_to_done("bp", 60);
    chk("bp_done_cyc", 32'(done_rel), 32'd20);
    chk("bp_stall_used", 32'(stall_left), 32'd0);
    chk("bp_ntx", 32'(tx_addr.size()), 32'd8);
    check_writeback("bp", 32'h0000_8000);

    // Spurious rvalid in IDLE
    clear_logs();
    spur_rvalid = 1;
    repeat (3) step();
    spur_rvalid = 0;
    chk("spur_idle_nwr", 32'(wr_idx.size()), 32'd0);

    // Spurious rvalid during a stalled WB_SEND
    clear_logs();
    spur_on_stall = 1;
    stall_addr = 32'h0000_8004;
    stall_left = 2;
    start_miss(32'h0000_4000, 1'b1, 32'h0000_8000);
    run_to_done("spur_wb", 60);
    chk("spur_wb_done_cyc", 32'(done_rel), 32'd19);
    check_writeback("spur_wb", 32'h0000_8000);
    check_refill("spur_wb", 32'h0000_4000, 4);

    // Spurious rvalid during a stalled RF_REQ
    clear_logs();
    stall_addr = 32'h0000_4008;
    stall_left = 2;
    start_miss(32'h0000_4000, 1'b0, 32'h0);
    run_to_done("spur_rf", 40);
    chk("spur_rf_done_cyc", 32'(done_rel), 32'd11);
    check_refill("spur_rf", 32'h0000_4000, 0);
    spur_on_stall = 0;
    stall_addr = 32'hFFFF_FFFF;

    // Reset during RF_WAIT of word 1
    clear_logs();
    start_miss(32'h0000_2000, 1'b0, 32'h0);
    for (int k = 0; k < 20 && tx_addr.size() < 2; k++) step();
    chk("rstmid_reads", 32'(tx_addr.size()), 32'd2);
    #1;
    reset = 1'b1;
    read_pending = 0;
    step();
    #1;
    reset = 1'b0;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_miss_ready", 32'(miss_ready), 32'd1);
    spur_rvalid = 1;
    repeat (2) step();
    spur_rvalid = 0;
    chk("rstmid_nwr", 32'(wr_idx.size()), 32'd1);
    clear_logs();
    start_miss(32'h0000_3000, 1'b0, 32'h0);
    run_to_done("after_rst", 40);
    chk("after_rst_done_cyc", 32'(done_rel), 32'd9);
    check_refill("after_rst", 32'h0000_3000, 0);

    // miss_valid held high: one acceptance per IDLE visit, back-to-back
    clear_logs();
    hold_valid = 1;
    start_miss(32'h0000_5000, 1'b0, 32'h0);
    run_to_done("hold", 40);
    chk("hold_accepts", 32'(accept_cnt), 32'd1);
    chk("hold_done_cyc", 32'(done_rel), 32'd9);
    step();
    chk("b2b_accepts", 32'(accept_cnt), 32'd2);
    chk("b2b_accept_cyc", 32'(accept_cyc[1]), 32'(done_abs + 1));
    hold_valid = 0;
    run_to_done("b2b", 40);
    chk("b2b_done_cyc", 32'(done_rel), 32'd9);
    chk("b2b_accepts_end", 32'(accept_cnt), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
